// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in, serial-out serializer:
// the state encoding and the counter-width helper.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Smallest width that can index value distinct positions (value >= 2).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((32'sd1 <<< width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out handshake bundle between a word producer, the serializer
// and the downstream shift register.
interface piso_serializer_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          en;
    logic          out;
    logic          out_valid;
    logic          last;

    modport master (
        output in_valid, in_data, en,
        input  in_ready, out, out_valid, last
    );

    modport slave (
        input  in_valid, in_data, en,
        output in_ready, out, out_valid, last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: takes a DW-bit word over valid/ready and
// emits one bit per enabled cycle, MSB first unless LSB_FIRST is set.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DW        = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);

    localparam int             CW       = clog2(DW);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

    state_t        state_r;
    logic [DW-1:0] sreg_r;
    logic [CW-1:0] cnt_r;

    logic          at_last_s;
    logic          out_valid_s;
    logic          ready_st_s;
    logic          in_ready_s;
    logic          last_s;
    logic          out_s;
    logic          accept_s;

    // Handshake and serial outputs decoded from the state, counter and shift register.
    always_comb begin
        out_valid_s = 1'b0;
        ready_st_s  = 1'b0;
        at_last_s   = (cnt_r == CNT_LAST);
        case (state_r)
            IDLE: begin
                out_valid_s = 1'b0;
                ready_st_s  = 1'b1;
            end
            SHIFT: begin
                out_valid_s = 1'b1;
                // A new word may only enter as the final bit is being consumed.
                ready_st_s  = at_last_s && bus.en;
            end
            default: begin
                out_valid_s = 1'b0;
                ready_st_s  = 1'b0;
            end
        endcase
        in_ready_s = rst ? 1'b0 : ready_st_s;
        last_s     = out_valid_s && at_last_s;
        if (out_valid_s) begin
            out_s = LSB_FIRST ? sreg_r[0] : sreg_r[DW-1];
        end else begin
            out_s = 1'b0;
        end
        accept_s = bus.in_valid && in_ready_s;
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out       = out_s;
    assign bus.last      = last_s;

    // State, bit counter and shift register; en=0 in SHIFT holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sreg_r  <= '0;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sreg_r  <= bus.in_data;
                        cnt_r   <= CNT_ZERO;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bus.en) begin
                        if (at_last_s) begin
                            if (accept_s) begin
                                sreg_r  <= bus.in_data;
                                cnt_r   <= CNT_ZERO;
                                state_r <= SHIFT;
                            end else begin
                                sreg_r  <= '0;
                                cnt_r   <= CNT_ZERO;
                                state_r <= IDLE;
                            end
                        end else begin
                            cnt_r  <= cnt_r + CNT_ONE;
                            sreg_r <= LSB_FIRST ? {1'b0, sreg_r[DW-1:1]}
                                                : {sreg_r[DW-2:0], 1'b0};
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sreg_r  <= '0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first instance feeding a modelled
// receiver shift register, plus an LSB-first instance.
module tb_piso_serializer;

    logic clk;
    logic rst;

    piso_serializer_if #(.DW(8)) a_if ();
    piso_serializer_if #(.DW(8)) b_if ();

    piso_serializer #(.DW(8), .LSB_FIRST(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    piso_serializer #(.DW(8), .LSB_FIRST(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int          n_checks;
    int          n_pass;
    int          nbits;
    logic [15:0] rx;
    logic [15:0] lastv;
    logic [15:0] readyv;
    logic [15:0] validv;
    logic [7:0]  bv;
    logic [7:0]  blv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model: a bit is consumed when out_valid && en and no reset.
    task automatic cyc();
        #2;
        if (a_if.out_valid && a_if.en && !rst) begin
            rx    = {rx[14:0], a_if.out};
            lastv = {lastv[14:0], a_if.last};
            nbits = nbits + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx    = 16'h0000;
        lastv = 16'h0000;
        nbits = 0;
    endtask

    task automatic b_word(input logic [7:0] w, output logic [7:0] bits, output logic [7:0] lasts);
        bits  = 8'h00;
        lasts = 8'h00;
        b_if.in_valid = 1'b1;
        b_if.in_data  = w;
        b_if.en       = 1'b1;
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            bits  = {bits[6:0], b_if.out};
            lasts = {lasts[6:0], b_if.last};
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_rx();
        rst = 1'b1;
        a_if.in_valid = 1'b0; a_if.in_data = 8'h00; a_if.en = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = 8'h00; b_if.en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        check("rst_in_ready", 32'(a_if.in_ready), 32'd0);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out", 32'(a_if.out), 32'd0);
        check("rst_last", 32'(a_if.last), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(a_if.in_ready), 32'd1);

        // Basic word 0xA5
        a_if.in_valid = 1'b1; a_if.in_data = 8'hA5; a_if.en = 1'b1;
        cyc();
        a_if.in_valid = 1'b0;
        check("basic_first_bit", 32'(a_if.out), 32'd1);
        repeat (8) cyc();
        check("basic_rx", 32'(rx[7:0]), 32'hA5);
        check("basic_last", 32'(lastv[7:0]), 32'h01);
        check("basic_nbits", 32'(nbits), 32'd8);
        check("basic_idle", 32'(a_if.out_valid), 32'd0);

        // Back-to-back 0x3C then 0xC3
        clear_rx();
        readyv = 16'h0000; validv = 16'h0000;
        a_if.in_valid = 1'b1; a_if.in_data = 8'h3C;
        cyc();
        a_if.in_data = 8'hC3;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) a_if.in_valid = 1'b0;
            #1;
            readyv = {readyv[14:0], a_if.in_ready};
            validv = {validv[14:0], a_if.out_valid};
            cyc();
        end
        check("b2b_valid", 32'(validv), 32'hFFFF);
        check("b2b_ready", 32'(readyv), 32'h0101);
        check("b2b_rx", 32'(rx), 32'h3CC3);
        check("b2b_last", 32'(lastv), 32'h0101);
        check("b2b_nbits", 32'(nbits), 32'd16);
        check("b2b_idle", 32'(a_if.out_valid), 32'd0);

        // Stall on word cycles 2-4
        clear_rx();
        a_if.in_valid = 1'b1; a_if.in_data = 8'h81;
        cyc();
        a_if.in_valid = 1'b0;
        cyc();
        a_if.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_out", 32'(a_if.out), 32'd0);
            check("stall_valid", 32'(a_if.out_valid), 32'd1);
            check("stall_last", 32'(a_if.last), 32'd0);
            cyc();
        end
        a_if.en = 1'b1;
        repeat (7) cyc();
        check("stall_rx", 32'(rx[7:0]), 32'h81);
        check("stall_nbits", 32'(nbits), 32'd8);
        check("stall_lastv", 32'(lastv[7:0]), 32'h01);
        check("stall_idle", 32'(a_if.out_valid), 32'd0);

        // Reset mid-word, then 0x0F
        clear_rx();
        a_if.in_valid = 1'b1; a_if.in_data = 8'hFF;
        cyc();
        a_if.in_valid = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        check("midrst_ready_low", 32'(a_if.in_ready), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(a_if.out_valid), 32'd0);
        check("midrst_out", 32'(a_if.out), 32'd0);
        check("midrst_ready", 32'(a_if.in_ready), 32'd1);
        check("midrst_nbits", 32'(nbits), 32'd3);
        clear_rx();
        a_if.in_valid = 1'b1; a_if.in_data = 8'h0F;
        cyc();
        a_if.in_valid = 1'b0;
        repeat (8) cyc();
        check("after_rst_rx", 32'(rx[7:0]), 32'h0F);
        check("after_rst_last", 32'(lastv[7:0]), 32'h01);
        check("after_rst_nbits", 32'(nbits), 32'd8);

        // in_valid ignored mid-word
        clear_rx();
        a_if.in_valid = 1'b1; a_if.in_data = 8'hE1;
        cyc();
        a_if.in_data = 8'h55;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) a_if.in_valid = 1'b0;
            #1;
            if (k == 1) check("ignore_ready", 32'(a_if.in_ready), 32'd0);
            cyc();
        end
        check("ignore_rx", 32'(rx[7:0]), 32'hE1);
        check("ignore_nbits", 32'(nbits), 32'd8);
        check("ignore_idle", 32'(a_if.out_valid), 32'd0);

        // LSB-first instance
        b_word(8'h01, bv, blv);
        check("lsb_01_bits", 32'(bv), 32'h80);
        check("lsb_01_last", 32'(blv), 32'h01);
        b_word(8'hB2, bv, blv);
        check("lsb_b2_bits", 32'(bv), 32'h4D);
        check("lsb_idle", 32'(b_if.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out serializer; transmit-side counterpart of the team's serial-in/parallel-out shift register.
- Accepts a DW-bit word over a valid/ready handshake and emits it one bit per enabled cycle.
- Its out_valid drives the receiver's shift enable directly, and its out drives the receiver's serial input.
- With default MSB-first order, the receiver's parallel output equals the sent word after DW enabled shifts.

Parameters:
- DW, 8, word width in bits; legal range DW >= 2.
- LSB_FIRST, 0, bit order: 0 sends bit DW-1 first (matches the receiver), 1 sends bit 0 first.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  parallel word is present on in_data.
- in_ready  output  1  serializer can accept a word this cycle.
- in_data  input  DW  parallel word to send.
- en  input  1  downstream shift enable; a bit is consumed on a cycle with out_valid && en.
- out  output  1  current serial bit.
- out_valid  output  1  out holds a valid bit (connect to receiver en, gated by en).
- last  output  1  out holds the final bit of the current word.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, sreg=0, cnt=0, out=0, out_valid=0, last=0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-word abandons the word with no partial completion; the first cycle after reset is IDLE with in_ready=1.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - SHIFT: out_valid=1; in_ready=1 only when last && en, otherwise 0.
- Accept: a word is accepted on a cycle with in_valid && in_ready.
  - sreg <= in_data, cnt <= 0, state <= SHIFT.
  - The first bit appears on out the following cycle (latency 1).
- Shift: in SHIFT, on en=1:
  - If cnt < DW-1: cnt increments and sreg shifts one position.
    - LSB_FIRST=0: left shift, zero fill.
    - LSB_FIRST=1: right shift, zero fill.
  - If cnt == DW-1 (last bit consumed): go to IDLE, unless a new word is accepted the same cycle. In that case reload, stay in SHIFT, cnt=0. This gives back-to-back words with no bubble.
- Stall: in SHIFT with en=0, sreg, cnt, out and last all hold; no bit is lost or repeated.
- Outputs are combinational from registers only, never from inputs except in_ready, which depends on en:
  - out = sreg[DW-1] when LSB_FIRST=0, else sreg[0].
  - last = out_valid && (cnt == DW-1).
- out = 0 whenever out_valid = 0.
- in_valid while in_ready=0 is ignored; in_data is not sampled.
- cnt width = clog2(DW); cnt never exceeds DW-1.
- Throughput: one word per DW cycles with en held high.

Decomposition:
- Package piso_pkg holds:
  - the state encoding (IDLE=1'b0, SHIFT=1'b1);
  - a clog2 helper function for cnt width.
- No sub-module: a single flat module with state reg, counter and shift reg.
- Bench instantiates the existing receiver shift register as the reference sink.

Test Plan:
- Basic word: DW=8, LSB_FIRST=0, en=1, load 0xA5 → out over 8 cycles = 1,0,1,0,0,1,0,1; last high on the 8th bit only; receiver out == 0xA5.
- Back-to-back: in_valid held high with 0x3C then 0xC3, en=1 → 16 consecutive valid bits with no gap; in_ready pulses on the last cycle of each word; receiver reads 0x3C then 0xC3.
- Stall: load 0x81, en=0 for cycles 2–4 of the word → out and last hold; the sequence is still exactly 1,0,0,0,0,0,0,1 with no duplicate or lost bits.
- Reset mid-word: load 0xFF, assert rst after the 3rd bit → next cycle out_valid=0, out=0, in_ready=1; a following load of 0x0F transmits correctly.
- Ignored input: in_valid=1 with 0x55 during SHIFT (not last) → 0x55 is not captured; the word in flight completes unchanged.
- LSB_FIRST=1: load 0x01 → out = 1 followed by seven 0s.
